// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch port, data port and external bus signals of mem_bus_arbiter
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic [1:0]  dm_op;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wrstb;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wrstb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  modport master (
    input  if_req, if_addr, dm_req, dm_op, dm_addr, dm_wdata, dm_wrstb, bus_ack, bus_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           bus_req, bus_we, bus_addr, bus_wdata, bus_wrstb
  );
  modport slave (
    output if_req, if_addr, dm_req, dm_op, dm_addr, dm_wdata, dm_wrstb, bus_ack, bus_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err, dm_gnt, dm_rvalid, dm_rdata, dm_err,
           bus_req, bus_we, bus_addr, bus_wdata, bus_wrstb
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 32-bit memory bus between fetch and data ports, data first with starvation bound; MEM_ARB_TIMEOUT_EN adds a bus timeout abort
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst_n,
  mem_bus_arbiter_if.master arb
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_e;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_STORE   = 2'b10;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  state_e      r_state, w_state;
  logic [3:0]  r_starve;
  logic        w_dm_valid, w_if_win, w_dm_win, w_if_gnt, w_dm_gnt, w_done, w_tmo;
  logic        r_bus_req, r_bus_we;
  logic [31:0] r_bus_addr, r_bus_wdata;
  logic [3:0]  r_bus_wrstb;
  logic        r_if_rvalid, r_dm_rvalid, r_if_err, r_dm_err;
  logic [31:0] r_if_rdata, r_dm_rdata;
  assign w_dm_valid = arb.dm_req && (arb.dm_op == OP_LOAD || arb.dm_op == OP_STORE);
  assign w_if_win   = arb.if_req && (!w_dm_valid || r_starve == STARVE_MAX);
  assign w_dm_win   = w_dm_valid && !w_if_win;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_tmo;
  assign w_tmo = r_state != IDLE && !arb.bus_ack && r_tmo == TMO_LAST;
  // count busy cycles without ack, restarting on every grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_tmo <= '0;
    else if (w_if_gnt || w_dm_gnt) r_tmo <= '0;
    else if (r_state != IDLE && !arb.bus_ack) r_tmo <= r_tmo + 8'd1;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = TIMEOUT_CYCLES == 0;
  assign w_tmo        = 1'b0;
`endif
  // grant decision while idle, completion (ack or abort) while busy
  always_comb begin
    w_state  = r_state;
    w_if_gnt = 1'b0;
    w_dm_gnt = 1'b0;
    w_done   = 1'b0;
    if (r_state == IDLE) begin
      w_if_gnt = w_if_win;
      w_dm_gnt = w_dm_win;
      w_state  = w_if_win ? BUSY_IF : w_dm_win ? BUSY_DM : IDLE;
    end else begin
      w_done  = arb.bus_ack || w_tmo;
      w_state = w_done ? IDLE : r_state;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state;
  // consecutive data grants while a fetch waits; cleared by a fetch grant or an idle cycle with no fetch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_starve <= '0;
    else if (r_state == IDLE)
      r_starve <= (w_if_gnt || !arb.if_req) ? '0 :
                  (w_dm_gnt && r_starve != STARVE_MAX) ? r_starve + 4'd1 : r_starve;
  // bus cycle registers, captured at grant and held until completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wrstb <= '0;
    end else begin
      r_bus_req <= w_state != IDLE;
      if (w_if_gnt) begin
        r_bus_we    <= 1'b0;
        r_bus_addr  <= arb.if_addr;
        r_bus_wdata <= '0;
        r_bus_wrstb <= '0;
      end else if (w_dm_gnt) begin
        r_bus_we    <= arb.dm_op == OP_STORE;
        r_bus_addr  <= arb.dm_addr;
        r_bus_wdata <= arb.dm_op == OP_STORE ? arb.dm_wdata : '0;
        r_bus_wrstb <= arb.dm_op == OP_STORE ? arb.dm_wrstb : '0;
      end
    end
  // one-cycle response to the owner; rdata is zero except on an acked read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_dm_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_done && r_state == BUSY_IF;
      r_dm_rvalid <= w_done && r_state == BUSY_DM;
      r_if_err    <= w_tmo && r_state == BUSY_IF;
      r_dm_err    <= w_tmo && r_state == BUSY_DM;
      r_if_rdata  <= (arb.bus_ack && r_state == BUSY_IF) ? arb.bus_rdata : '0;
      r_dm_rdata  <= (arb.bus_ack && r_state == BUSY_DM && !r_bus_we) ? arb.bus_rdata : '0;
    end
  assign arb.if_gnt    = w_if_gnt;
  assign arb.dm_gnt    = w_dm_gnt;
  assign arb.if_rvalid = r_if_rvalid;
  assign arb.if_rdata  = r_if_rdata;
  assign arb.if_err    = r_if_err;
  assign arb.dm_rvalid = r_dm_rvalid;
  assign arb.dm_rdata  = r_dm_rdata;
  assign arb.dm_err    = r_dm_err;
  assign arb.bus_req   = r_bus_req;
  assign arb.bus_we    = r_bus_we;
  assign arb.bus_addr  = r_bus_addr;
  assign arb.bus_wdata = r_bus_wdata;
  assign arb.bus_wrstb = r_bus_wrstb;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table plus directed sequences with a response scoreboard for mem_bus_arbiter
module tb_mem_bus_arbiter;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif
  localparam int SL = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_bus_arbiter_if ifc();
  mem_bus_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .arb(ifc));

  typedef struct {
    logic dm; logic [31:0] rdata; logic err;
    logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wrstb;
  } exp_t;
  typedef struct {
    logic if_req; logic [31:0] if_addr; logic dm_req; logic [1:0] dm_op;
    logic [31:0] dm_addr; logic [31:0] dm_wdata; logic [3:0] dm_wrstb; int wt; int first;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_cmp = 0, n_fail = 0;
  int ack_wait = 0, wcnt = 0;
  bit ack_en = 1'b1, use_fix = 1'b0, tmo_mode = 1'b0;
  logic [31:0] fix_data = '0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // records any grant seen now and pushes the response the bench expects for it
  task automatic note_grants(output bit gi, output bit gd);
    bit st;
    gi = ifc.if_gnt;
    gd = ifc.dm_gnt;
    if (gi || gd) chk("single_gnt", 32'(gi & gd), 0);
    if (gi) sb.push_back('{dm: 1'b0, rdata: tmo_mode ? 32'h0 : use_fix ? fix_data : mem_f(ifc.if_addr),
                           err: tmo_mode, addr: ifc.if_addr, we: 1'b0, wdata: 32'h0, wrstb: 4'h0});
    else if (gd) begin
      st = ifc.dm_op == 2'b10;
      sb.push_back('{dm: 1'b1, rdata: (st || tmo_mode) ? 32'h0 : use_fix ? fix_data : mem_f(ifc.dm_addr),
                     err: tmo_mode, addr: ifc.dm_addr, we: st, wdata: ifc.dm_wdata,
                     wrstb: st ? ifc.dm_wrstb : 4'h0});
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) begin @(negedge clk); #3; end
    chk(name, 32'(sb.size()), 0);
  endtask

  // memory model: acks after ack_wait extra busy cycles
  always @(negedge clk) if (ack_en) begin
    if (ifc.bus_req && wcnt >= ack_wait) begin
      ifc.bus_ack   = 1'b1;
      ifc.bus_rdata = use_fix ? fix_data : mem_f(ifc.bus_addr);
      wcnt = 0;
    end else begin
      ifc.bus_ack   = 1'b0;
      ifc.bus_rdata = $urandom;
      wcnt = ifc.bus_req ? wcnt + 1 : 0;
    end
  end

  // scoreboard consumer: bus fields at ack, response at rvalid
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (ifc.bus_req && ifc.bus_ack) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL bus_ack_sb: got ack with empty scoreboard, expected a pending entry");
        end else begin
          chk("bus_addr", ifc.bus_addr, sb[0].addr);
          chk("bus_we", 32'(ifc.bus_we), 32'(sb[0].we));
          chk("bus_wrstb", 32'(ifc.bus_wrstb), 32'(sb[0].wrstb));
          if (sb[0].we) chk("bus_wdata", ifc.bus_wdata, sb[0].wdata);
        end
      end
      if (ifc.if_rvalid || ifc.dm_rvalid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rvalid_sb: got rvalid with empty scoreboard, expected a pending entry");
        end else begin
          mon_e = sb.pop_front();
          chk("rvalid_port", 32'({ifc.if_rvalid, ifc.dm_rvalid}), mon_e.dm ? 32'd1 : 32'd2);
          chk("rdata", mon_e.dm ? ifc.dm_rdata : ifc.if_rdata, mon_e.rdata);
          chk("err", 32'(mon_e.dm ? ifc.dm_err : ifc.if_err), 32'(mon_e.err));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    bit gi, gd;
    int got, need, first, run, nif, last, gap_bad, nb, nrv;
    int runs[2];
    vt[0] = '{1'b1, 32'h100, 1'b0, 2'b00, 32'h0,    32'h0,         4'h0, 0, 0};
    vt[1] = '{1'b0, 32'h0,   1'b1, 2'b01, 32'h2000, 32'h0,         4'h0, 1, 1};
    vt[2] = '{1'b1, 32'h104, 1'b1, 2'b01, 32'h2000, 32'h0,         4'h0, 0, 1};
    vt[3] = '{1'b0, 32'h0,   1'b1, 2'b10, 32'h44,   32'hA5A50F0F,  4'hC, 2, 1};
    vt[4] = '{1'b0, 32'h0,   1'b1, 2'b00, 32'h50,   32'h0,         4'h0, 0, 2};
    vt[5] = '{1'b1, 32'h200, 1'b1, 2'b11, 32'h54,   32'h0,         4'h0, 0, 0};
    vt[6] = '{1'b1, 32'h208, 1'b1, 2'b10, 32'h48,   32'h01020304,  4'h5, 3, 1};
    vt[7] = '{1'b1, 32'h300, 1'b0, 2'b01, 32'h58,   32'h0,         4'h0, 1, 0};
    ifc.if_req = 0; ifc.if_addr = 0; ifc.dm_req = 0; ifc.dm_op = 0;
    ifc.dm_addr = 0; ifc.dm_wdata = 0; ifc.dm_wrstb = 0; ifc.bus_ack = 0; ifc.bus_rdata = 0;

    // reset state
    @(negedge clk); #1;
    chk("rst_ctl", 32'({ifc.if_gnt, ifc.if_rvalid, ifc.if_err, ifc.dm_gnt, ifc.dm_rvalid, ifc.dm_err,
                        ifc.bus_req, ifc.bus_we, ifc.bus_wrstb}), 0);
    chk("rst_if_rdata", ifc.if_rdata, 0);
    chk("rst_dm_rdata", ifc.dm_rdata, 0);
    chk("rst_bus_addr", ifc.bus_addr, 0);
    chk("rst_bus_wdata", ifc.bus_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // fetch-only latency: gnt G, bus_req G+1..G+2, rvalid G+3
    @(negedge clk);
    use_fix = 1'b1; fix_data = 32'hDEADBEEF; ack_wait = 1;
    ifc.if_req = 1'b1; ifc.if_addr = 32'h100; #1;
    note_grants(gi, gd);
    chk("fetch_gnt_G", 32'(gi), 1);
    @(posedge clk); #1; ifc.if_req = 1'b0;
    @(negedge clk); #1;
    chk("fetch_breq_G1", 32'(ifc.bus_req), 1);
    chk("fetch_baddr_G1", ifc.bus_addr, 32'h100);
    @(negedge clk); #1;
    chk("fetch_breq_G2", 32'(ifc.bus_req), 1);
    chk("fetch_rv_G2", 32'(ifc.if_rvalid), 0);
    @(negedge clk); #1;
    chk("fetch_rv_G3", 32'(ifc.if_rvalid), 1);
    chk("fetch_rdata_G3", ifc.if_rdata, 32'hDEADBEEF);
    chk("fetch_breq_G3", 32'(ifc.bus_req), 0);
    drain("fetch_drain");
    use_fix = 1'b0;

    // vector table
    foreach (vt[k]) begin
      @(negedge clk);
      ack_wait = vt[k].wt;
      ifc.if_req = vt[k].if_req; ifc.if_addr = vt[k].if_addr;
      ifc.dm_req = vt[k].dm_req; ifc.dm_op = vt[k].dm_op; ifc.dm_addr = vt[k].dm_addr;
      ifc.dm_wdata = vt[k].dm_wdata; ifc.dm_wrstb = vt[k].dm_wrstb;
      #1;
      need = int'(vt[k].if_req) + int'(vt[k].dm_req && (vt[k].dm_op == 2'b01 || vt[k].dm_op == 2'b10));
      got = 0; first = 2;
      for (int c = 0; c < 60 && got < need; c++) begin
        note_grants(gi, gd);
        if ((gi || gd) && first == 2) first = gi ? 0 : 1;
        got += int'(gi) + int'(gd);
        @(posedge clk); #1;
        if (gi) ifc.if_req = 1'b0;
        if (gd) ifc.dm_req = 1'b0;
        @(negedge clk); #1;
      end
      if (need == 0)
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("v%0d_idle", k), 32'({ifc.if_gnt, ifc.dm_gnt, ifc.bus_req}), 0);
          @(negedge clk); #1;
        end
      chk($sformatf("v%0d_first", k), first, vt[k].first);
      chk($sformatf("v%0d_grants", k), got, need);
      ifc.if_req = 1'b0; ifc.dm_req = 1'b0;
      drain($sformatf("v%0d_drain", k));
    end

    // starvation: fetch held against back-to-back stores
    @(negedge clk);
    ack_wait = 0;
    ifc.if_req = 1'b1; ifc.if_addr = 32'h500;
    ifc.dm_req = 1'b1; ifc.dm_op = 2'b10; ifc.dm_addr = 32'h1000; ifc.dm_wdata = 32'hC0DE0000; ifc.dm_wrstb = 4'hF;
    #1;
    run = 0; nif = 0; last = -1; gap_bad = 0; runs[0] = 0; runs[1] = 0;
    for (int c = 0; c < 100 && nif < 2; c++) begin
      note_grants(gi, gd);
      if (gi || gd) begin
        if (last >= 0 && c - last != 2) gap_bad++;
        last = c;
      end
      if (gd) run++;
      if (gi) begin runs[nif] = run; nif++; run = 0; end
      @(posedge clk); #1;
      if (gd) begin ifc.dm_addr += 4; ifc.dm_wdata += 1; end
      if (gi) ifc.if_addr += 4;
      @(negedge clk); #1;
    end
    ifc.if_req = 1'b0; ifc.dm_req = 1'b0;
    chk("starve_if_gnts", nif, 2);
    chk("starve_run0", runs[0], SL);
    chk("starve_run1", runs[1], SL);
    chk("starve_gnt_gap", gap_bad, 0);
    drain("starve_drain");

    // store held stable on the bus until ack, completion with zero rdata
    @(negedge clk);
    ack_wait = 3;
    ifc.dm_req = 1'b1; ifc.dm_op = 2'b10; ifc.dm_addr = 32'h40; ifc.dm_wdata = 32'h12345678; ifc.dm_wrstb = 4'b0011;
    #1;
    note_grants(gi, gd);
    chk("store_gnt", 32'(gd), 1);
    @(posedge clk); #1; ifc.dm_req = 1'b0;
    @(negedge clk); #1;
    nb = 0;
    while (ifc.bus_req && nb < 20) begin
      chk("store_we", 32'(ifc.bus_we), 1);
      chk("store_addr", ifc.bus_addr, 32'h40);
      chk("store_wdata", ifc.bus_wdata, 32'h12345678);
      chk("store_wrstb", 32'(ifc.bus_wrstb), 32'h3);
      nb++;
      @(negedge clk); #1;
    end
    chk("store_busy_cycles", nb, 4);
    chk("store_rvalid", 32'(ifc.dm_rvalid), 1);
    chk("store_rdata", ifc.dm_rdata, 0);
    drain("store_drain");

    // ack while idle has no effect
    @(negedge clk);
    ack_en = 1'b0; ifc.bus_ack = 1'b1; ifc.bus_rdata = 32'hFFFF0000;
    nrv = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      nrv += int'(ifc.if_rvalid) + int'(ifc.dm_rvalid) + int'(ifc.bus_req);
    end
    chk("idle_ack_ignored", nrv, 0);
    ifc.bus_ack = 1'b0;

    // asynchronous reset in the middle of a load, late ack ignored
    @(negedge clk);
    ifc.dm_req = 1'b1; ifc.dm_op = 2'b01; ifc.dm_addr = 32'h3000; #1;
    note_grants(gi, gd);
    chk("rst_mid_gnt", 32'(gd), 1);
    @(posedge clk); #1; ifc.dm_req = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_mid_breq_before", 32'(ifc.bus_req), 1);
    rst_n = 1'b0; #1;
    chk("rst_mid_breq_after", 32'(ifc.bus_req), 0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    ifc.bus_ack = 1'b1; ifc.bus_rdata = 32'h0BADF00D;
    nrv = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      nrv += int'(ifc.if_rvalid) + int'(ifc.dm_rvalid) + int'(ifc.bus_req);
    end
    chk("late_ack_ignored", nrv, 0);
    ifc.bus_ack = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // no ack: abort after TMO busy cycles with err and zero rdata
    @(negedge clk);
    tmo_mode = 1'b1;
    ifc.dm_req = 1'b1; ifc.dm_op = 2'b01; ifc.dm_addr = 32'h80; #1;
    note_grants(gi, gd);
    tmo_mode = 1'b0;
    chk("tmo_gnt", 32'(gd), 1);
    @(posedge clk); #1; ifc.dm_req = 1'b0;
    nb = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk); #1;
      if (c == TMO) chk("tmo_breq_last", 32'(ifc.bus_req), 1);
      if (ifc.dm_rvalid) begin nb = c; break; end
    end
    chk("tmo_cycle", nb, TMO + 1);
    chk("tmo_err", 32'(ifc.dm_err), 1);
    chk("tmo_rdata", ifc.dm_rdata, 0);
    chk("tmo_breq_drop", 32'(ifc.bus_req), 0);
    ifc.if_req = 1'b1; ifc.if_addr = 32'h600; #1;
    wcnt = 0; ack_en = 1'b1; ack_wait = 0;
    note_grants(gi, gd);
    chk("tmo_idle_gnt", 32'(gi), 1);
    @(posedge clk); #1; ifc.if_req = 1'b0;
    drain("tmo_drain");
`else
    // no ack: the arbiter keeps waiting past any timeout value
    @(negedge clk);
    ifc.dm_req = 1'b1; ifc.dm_op = 2'b01; ifc.dm_addr = 32'h80; #1;
    note_grants(gi, gd);
    chk("wait_gnt", 32'(gd), 1);
    @(posedge clk); #1; ifc.dm_req = 1'b0;
    nrv = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      nrv += int'(ifc.dm_rvalid) + int'(ifc.dm_err) + int'(!ifc.bus_req);
    end
    chk("wait_forever", nrv, 0);
    wcnt = 0; ack_wait = 0; ack_en = 1'b1;
    drain("wait_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
